// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the instruction-fetch front end:
// fetch FSM state encoding, PC increment and the NOP encoding.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and
// instruction memory (slave).
interface if_fetch_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_hold_buf.sv
// One-entry instruction holding register that parks a fetched word while
// decode is stalled. Clear wins over load.
module if_hold_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = din;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: fetches at pc over req/ack, parks words in a
// hold buffer under decode stall, drains outstanding requests on redirect.
// Optional performance counters are built when IF_FETCH_PERF_EN is defined.
//
// state | meaning
// IDLE  | reset state, no request, moves to REQ next cycle
// REQ   | request at pc outstanding, waiting for ack
// HOLD  | fetched word parked in hold buffer while decode stalls
// DRAIN | discarding the response of a request cut short by a redirect
module if_fetch_unit
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              stall_if,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall_id,
    if_fetch_unit_if.master   imem,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_instr
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    logic [DATA_W-1:0] if_id_instr_q, if_id_instr_d;

    logic              advance;
    logic              if_id_load;
    logic              hold_load;
    logic              hold_clear;
    logic [DATA_W-1:0] hold_data;
    logic              hold_valid;
    logic              req;
    logic [ADDR_W-1:0] addr;

    if_hold_buf #(.W(DATA_W)) u_hold_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hold_load),
        .clear (hold_clear),
        .din   (imem.imem_rdata),
        .dout  (hold_data),
        .valid (hold_valid)
    );

    always_comb begin
        state_d       = state_q;
        drain_addr_d  = drain_addr_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        advance       = redirect_valid;
        if_id_load    = 1'b0;
        hold_load     = 1'b0;
        hold_clear    = 1'b0;
        req           = 1'b0;
        addr          = pc;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                req = 1'b1;
                if (imem.imem_ack && !stall_id) begin
                    advance       = 1'b1;
                    if_id_load    = 1'b1;
                    if_id_instr_d = imem.imem_rdata;
                end else if (imem.imem_ack) begin
                    hold_load = 1'b1;
                    state_d   = ST_HOLD;
                end else if (!stall_id) begin
                    if_id_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!stall_id) begin
                    advance       = 1'b1;
                    if_id_load    = hold_valid;
                    if_id_instr_d = hold_data;
                    hold_clear    = 1'b1;
                    state_d       = ST_REQ;
                end
            end
            ST_DRAIN: begin
                req  = 1'b1;
                addr = drain_addr_q;
                if (imem.imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (if_id_load) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = pc;
        end

        // Redirect beats decode stall; the old request keeps its address until acked.
        if (redirect_valid) begin
            if_id_valid_d = 1'b0;
            if_id_load    = 1'b0;
            hold_load     = 1'b0;
            hold_clear    = 1'b1;
            if (state_q == ST_REQ && !imem.imem_ack) begin
                drain_addr_d = pc;
                state_d      = ST_DRAIN;
            end else if (state_q == ST_DRAIN && !imem.imem_ack) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            drain_addr_q  <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= DATA_W'(NOP_INSTR);
        end else begin
            state_q       <= state_d;
            drain_addr_q  <= drain_addr_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    assign stall_if       = !advance;
    assign next_pc        = redirect_valid ? redirect_pc : pc + ADDR_W'(PC_INC);
    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_instr    = if_id_instr_q;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, if_id_load};
        perf_stall_d = perf_stall_q + {31'd0, (stall_if && state_q != ST_IDLE)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scoreboard bench for if_fetch_unit: models the PC register and a
// memory returning addr ^ 32'hA5A5_0000, checks fetch, stall, hold, redirect.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        stall_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_id;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    logic [31:0] mpc;
    logic [31:0] last_pc;
    logic [63:0] sb[$];

    if_fetch_unit_if #(.DATA_W(32), .ADDR_W(32)) imem ();

    if_fetch_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .next_pc        (next_pc),
        .stall_if       (stall_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_id       (stall_id),
        .imem           (imem),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign imem.imem_rdata = imem.imem_addr ^ KEY;

    // PC register environment
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= 32'h0;
        else if (!stall_if)
            pc <= next_pc;
    end

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    task automatic step(input logic ack, input logic sid, input logic rv,
                        input logic [31:0] rpc, input logic ereq,
                        input logic [31:0] eaddr, input logic estall,
                        input logic push, input logic pop, input logic ev);
        logic [63:0] e;
        @(negedge clk);
        imem.imem_ack  = ack;
        stall_id       = sid;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        chk("imem_req", {31'd0, imem.imem_req}, {31'd0, ereq});
        if (ereq) chk("imem_addr", imem.imem_addr, eaddr);
        chk("stall_if", {31'd0, stall_if}, {31'd0, estall});
        if (!estall) chk("next_pc", next_pc, rv ? rpc : mpc + 32'd4);
        if (push) sb.push_back({mpc, mpc ^ KEY});
        @(posedge clk);
        #1;
        if (!estall) mpc = rv ? rpc : mpc + 32'd4;
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, ev});
        if (pop) begin
            n_pops++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("if_id_pc", if_id_pc, e[63:32]);
                chk("if_id_instr", if_id_instr, e[31:0]);
                last_pc = e[63:32];
            end
        end else if (ev) begin
            chk("if_id_pc_held", if_id_pc, last_pc);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem.imem_ack  = 1'b0;
        stall_id       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mpc            = 32'h0;
        last_pc        = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("rst_addr", imem.imem_addr, 32'h0);
        chk("rst_stall", {31'd0, stall_if}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // IDLE, then zero-wait fetches 0..0xC
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, mpc, 0, 1, 1, 1);

        // ack delayed 3 cycles at 0x10
        repeat (3) step(0, 0, 0, 0, 1, 32'h10, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h10, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, mpc, 0, 1, 1, 1);

        // decode stall for 4 cycles when 0x20 is acked
        step(1, 1, 0, 0, 1, 32'h20, 1, 1, 0, 1);
        repeat (3) step(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 32'h24, 0, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, mpc, 0, 1, 1, 1);

        // redirect to 0x100 with request to 0x40 outstanding
        step(0, 0, 1, 32'h100, 1, 32'h40, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h40, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h40, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h100, 0, 1, 1, 1);

        // redirect while parked in HOLD under decode stall
        step(1, 1, 0, 0, 1, 32'h104, 1, 0, 0, 1);
        step(0, 1, 1, 32'h200, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h200, 0, 1, 1, 1);
        step(1, 0, 0, 0, 1, 32'h204, 0, 1, 1, 1);

        // second redirect during DRAIN replaces the target, drain address stays
        step(0, 0, 1, 32'h300, 1, 32'h208, 0, 0, 0, 0);
        step(0, 0, 1, 32'h400, 1, 32'h208, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h208, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h400, 0, 1, 1, 1);

        // redirect with ack present, then pc wrap at the top of the space
        step(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h404, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, 1, 1);
        step(1, 0, 0, 0, 1, 32'h0, 0, 1, 1, 1);

        // asynchronous reset mid-operation, stale ack in IDLE ignored
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("midrst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall_if}, 32'd1);
        mpc    = 32'h0;
        n_pops = 0;
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h0, 0, 1, 1, 1);
        step(1, 0, 0, 0, 1, 32'h4, 0, 1, 1, 1);

`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, n_pops);
`endif
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
